// File: rtl/id_hash_chain_verify.sv
// Board-ID authenticator: chains P_ROUNDS hash passes over the board ID
// through an external (shareable) hash engine. It then compares the final
// digest with the expected code and tracks fail count, timeout and lockout.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for an ID strobe
// ST_REQ  | hash request pulse on o_hash_vld for the current round
// ST_WAIT | waiting for the hash response, timeout timer running
// ST_CMP  | final digest held, waiting for the expected code, then compare
// ST_PASS | sticky pass verdict, held until i_clear
// ST_FAIL | sticky fail verdict, held until i_clear or escalated to lock
// ST_LOCK | permanent lockout, only i_rst leaves
module id_hash_chain_verify #(
    parameter int P_ID_W     = 16,
    parameter int P_DIG_W    = 256,
    parameter int P_ROUNDS   = 2,
    parameter int P_TIMEOUT  = 1024,
    parameter int P_MAX_FAIL = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [P_ID_W-1:0]  i_board_card,
    input  logic               i_board_card_vld,
    input  logic [P_DIG_W-1:0] i_udp_code_data,
    input  logic               i_udp_code_vld,
    input  logic               i_clear,
    output logic [P_DIG_W-1:0] o_hash_data,
    output logic               o_hash_vld,
    input  logic [P_DIG_W-1:0] i_hash_data,
    input  logic               i_hash_vld,
    output logic               o_busy,
    output logic [3:0]         o_round,
    output logic               o_verify_ok,
    output logic               o_verify_fail,
    output logic               o_timeout,
    output logic [3:0]         o_fail_cnt,
    output logic               o_locked
);

    localparam int         TMR_W    = $clog2(P_TIMEOUT);
    localparam logic [3:0] LAST_RND = 4'(P_ROUNDS - 1);
    localparam logic [3:0] MAX_FAIL = 4'(P_MAX_FAIL);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(P_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_REQ, ST_WAIT, ST_CMP, ST_PASS, ST_FAIL, ST_LOCK
    } state_t;

    state_t             state_q;
    logic [P_DIG_W-1:0] hash_data_q;
    logic               hash_vld_q;
    logic [P_DIG_W-1:0] digest_q;
    logic [P_DIG_W-1:0] exp_q;
    logic               exp_vld_q;
    logic [3:0]         round_q;
    logic [TMR_W-1:0]   timer_q;
    logic               busy_q;
    logic               ok_q;
    logic               fail_q;
    logic               tmo_q;
    logic [3:0]         fail_cnt_q;
    logic               locked_q;

    logic [3:0]         fail_cnt_d;
    logic               lock_due;

    // Saturating increment; a FAIL that has hit the limit must reach LOCK
    // even if i_clear arrives in that same cycle.
    assign fail_cnt_d = (fail_cnt_q == 4'hF) ? fail_cnt_q : fail_cnt_q + 4'd1;
    assign lock_due   = (state_q == ST_FAIL) && (fail_cnt_q >= MAX_FAIL);

    // Attempt sequencer with registered outputs and expected-code capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            hash_data_q <= '0;
            hash_vld_q  <= 1'b0;
            digest_q    <= '0;
            exp_q       <= '0;
            exp_vld_q   <= 1'b0;
            round_q     <= '0;
            timer_q     <= '0;
            busy_q      <= 1'b0;
            ok_q        <= 1'b0;
            fail_q      <= 1'b0;
            tmo_q       <= 1'b0;
            fail_cnt_q  <= '0;
            locked_q    <= 1'b0;
        end else begin
            hash_vld_q <= 1'b0;
            if (i_clear && (state_q != ST_LOCK) && !lock_due) begin
                state_q   <= ST_IDLE;
                busy_q    <= 1'b0;
                ok_q      <= 1'b0;
                fail_q    <= 1'b0;
                tmo_q     <= 1'b0;
                exp_vld_q <= 1'b0;
                round_q   <= '0;
                timer_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (i_board_card_vld) begin
                            hash_data_q <= P_DIG_W'(i_board_card);
                            hash_vld_q  <= 1'b1;
                            round_q     <= '0;
                            ok_q        <= 1'b0;
                            fail_q      <= 1'b0;
                            tmo_q       <= 1'b0;
                            busy_q      <= 1'b1;
                            state_q     <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        timer_q <= '0;
                        state_q <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (i_hash_vld) begin
                            digest_q <= i_hash_data;
                            if (round_q == LAST_RND) begin
                                state_q <= ST_CMP;
                            end else begin
                                round_q     <= round_q + 4'd1;
                                hash_data_q <= i_hash_data;
                                hash_vld_q  <= 1'b1;
                                state_q     <= ST_REQ;
                            end
                        end else if (timer_q == TMR_LAST) begin
                            tmo_q      <= 1'b1;
                            fail_q     <= 1'b1;
                            fail_cnt_q <= fail_cnt_d;
                            busy_q     <= 1'b0;
                            state_q    <= ST_FAIL;
                        end else begin
                            timer_q <= timer_q + TMR_W'(1);
                        end
                    end
                    ST_CMP: begin
                        if (exp_vld_q) begin
                            busy_q <= 1'b0;
                            if (digest_q == exp_q) begin
                                ok_q       <= 1'b1;
                                fail_cnt_q <= '0;
                                state_q    <= ST_PASS;
                            end else begin
                                fail_q     <= 1'b1;
                                fail_cnt_q <= fail_cnt_d;
                                state_q    <= ST_FAIL;
                            end
                        end
                    end
                    ST_FAIL: begin
                        if (lock_due) begin
                            locked_q <= 1'b1;
                            state_q  <= ST_LOCK;
                        end
                    end
                    ST_PASS, ST_LOCK: begin
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
            if (i_udp_code_vld) begin
                exp_q     <= i_udp_code_data;
                exp_vld_q <= 1'b1;
            end
        end
    end

    assign o_hash_data   = hash_data_q;
    assign o_hash_vld    = hash_vld_q;
    assign o_busy        = busy_q;
    assign o_round       = round_q;
    assign o_verify_ok   = ok_q;
    assign o_verify_fail = fail_q;
    assign o_timeout     = tmo_q;
    assign o_fail_cnt    = fail_cnt_q;
    assign o_locked      = locked_q;

endmodule

// File: tb/tb_id_hash_chain_verify.sv
// Bench for id_hash_chain_verify: hash engine model (digest = input + 1,
// fixed response latency) plus a verdict / fail-count reference model.
module tb_id_hash_chain_verify;

    localparam int ID_W  = 16;
    localparam int DIG_W = 256;
    localparam int ROUNDS = 2;
    localparam int TMO   = 1024;
    localparam int MAXF  = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [ID_W-1:0]  card;
    logic             card_vld;
    logic [DIG_W-1:0] code;
    logic             code_vld;
    logic             clr;
    logic [DIG_W-1:0] o_hash_data;
    logic             o_hash_vld;
    logic [DIG_W-1:0] hdata;
    logic             hvld;
    logic             o_busy;
    logic [3:0]       o_round;
    logic             o_verify_ok;
    logic             o_verify_fail;
    logic             o_timeout;
    logic [3:0]       o_fail_cnt;
    logic             o_locked;

    always #5 clk = ~clk;

    id_hash_chain_verify #(
        .P_ID_W(ID_W), .P_DIG_W(DIG_W), .P_ROUNDS(ROUNDS),
        .P_TIMEOUT(TMO), .P_MAX_FAIL(MAXF)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_board_card(card), .i_board_card_vld(card_vld),
        .i_udp_code_data(code), .i_udp_code_vld(code_vld),
        .i_clear(clr),
        .o_hash_data(o_hash_data), .o_hash_vld(o_hash_vld),
        .i_hash_data(hdata), .i_hash_vld(hvld),
        .o_busy(o_busy), .o_round(o_round),
        .o_verify_ok(o_verify_ok), .o_verify_fail(o_verify_fail),
        .o_timeout(o_timeout), .o_fail_cnt(o_fail_cnt), .o_locked(o_locked)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;
    int mfail  = 0;

    // hash engine model state
    logic [DIG_W-1:0] req_q[$];
    int               req_cyc[$];
    int               lat     = 40;
    int               req_num = 0;
    int               drop_at = 0;
    int               pend    = -1;
    logic [DIG_W-1:0] pend_data;

    // Engine: sees a request mid-cycle, answers input+1 'lat' cycles later.
    // The request numbered drop_at is answered only far past the timeout.
    initial begin
        hvld  = 1'b0;
        hdata = '0;
        forever begin
            @(negedge clk);
            hvld = 1'b0;
            if (pend > 0) pend--;
            if (pend == 0) begin
                hvld  = 1'b1;
                hdata = pend_data;
                pend  = -1;
            end
            if (o_hash_vld) begin
                req_num++;
                req_q.push_back(o_hash_data);
                req_cyc.push_back(cyc);
                pend_data = o_hash_data + 1;
                pend      = (req_num == drop_at) ? lat + 1100 : lat;
            end
        end
    end

    task automatic check(input string tag, input logic [DIG_W-1:0] got,
                         input logic [DIG_W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic send_code(input logic [DIG_W-1:0] v);
        code     = v;
        code_vld = 1'b1;
        tick(1);
        code_vld = 1'b0;
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    task automatic start_id(input logic [ID_W-1:0] id);
        req_q.delete();
        req_cyc.delete();
        card     = id;
        card_vld = 1'b1;
        tick(1);
        card_vld = 1'b0;
        check("req_latency", o_hash_vld, 1);
        check("req_round0", o_round, 0);
    endtask

    task automatic wait_verdict(input int budget);
        int n = 0;
        while (!(o_verify_ok || o_verify_fail) && n < budget) begin
            tick(1);
            n++;
        end
        if (!(o_verify_ok || o_verify_fail))
            check("verdict_wait", o_verify_ok | o_verify_fail, 1);
    endtask

    task automatic check_reqs(input logic [ID_W-1:0] id);
        check("req_count", req_q.size(), ROUNDS);
        for (int k = 0; k < ROUNDS && k < req_q.size(); k++)
            check("req_data", req_q[k], DIG_W'(id) + k);
    endtask

    // One full attempt; late_hold > 0 withholds the code that many cycles.
    task automatic run_attempt(input string tag, input logic [ID_W-1:0] id,
                               input logic [DIG_W-1:0] c, input int late_hold);
        logic [DIG_W-1:0] good;
        bit               pass;
        good = DIG_W'(id) + ROUNDS;
        pass = (c == good);
        if (late_hold == 0) send_code(c);
        start_id(id);
        if (late_hold > 0) begin
            tick(late_hold);
            check({tag, "_hold_busy"}, o_busy, 1);
            check({tag, "_hold_noverdict"}, o_verify_ok | o_verify_fail, 0);
            send_code(c);
            check({tag, "_code_edge"}, o_verify_ok | o_verify_fail, 0);
            tick(1);
        end else begin
            wait_verdict((lat + 4) * ROUNDS + 40);
        end
        check_reqs(id);
        if (pass) mfail = 0;
        else if (mfail < 15) mfail++;
        check({tag, "_ok"}, o_verify_ok, pass);
        check({tag, "_fail"}, o_verify_fail, !pass);
        check({tag, "_cnt"}, o_fail_cnt, mfail);
        check({tag, "_tmo"}, o_timeout, 0);
        check({tag, "_busy"}, o_busy, 0);
        tick(1);
        check({tag, "_locked"}, o_locked, mfail >= MAXF);
    endtask

    initial begin
        logic [ID_W-1:0]  rid;
        logic [DIG_W-1:0] good;
        int               n;
        rst = 1'b1; card = '0; card_vld = 1'b0;
        code = '0; code_vld = 1'b0; clr = 1'b0;
        do_reset();

        check("rst_ok", o_verify_ok, 0);
        check("rst_fail", o_verify_fail, 0);
        check("rst_tmo", o_timeout, 0);
        check("rst_busy", o_busy, 0);
        check("rst_cnt", o_fail_cnt, 0);
        check("rst_lock", o_locked, 0);
        check("rst_round", o_round, 0);
        check("rst_hvld", o_hash_vld, 0);

        // 1: pass with code sent first
        run_attempt("t1", 16'h1234, 256'h1236, 0);
        pulse_clear();

        // 2: mismatch, then clear keeps fail count
        run_attempt("t2", 16'h1234, 256'h1237, 0);
        pulse_clear();
        check("t2_clr_ok", o_verify_ok, 0);
        check("t2_clr_fail", o_verify_fail, 0);
        check("t2_clr_busy", o_busy, 0);
        check("t2_clr_cnt", o_fail_cnt, 1);

        // 3: code arrives 500 cycles after the final digest
        run_attempt("t3", 16'h1234, 256'h1236, (lat + 4) * ROUNDS + 500);
        pulse_clear();

        // 4: second response dropped -> timeout, late response ignored
        req_num = 0;
        drop_at = 2;
        send_code(256'h0BAF);
        start_id(16'h0BAD);
        n = 0;
        while (!o_verify_fail && n < 3000) begin
            tick(1);
            n++;
        end
        check("t4_fail_seen", o_verify_fail, 1);
        // request visible in cycle c is taken at the edge ending cycle c;
        // the timeout verdict lands P_TIMEOUT edges after that
        if (req_cyc.size() >= 2) check("t4_tmo_delay", cyc - req_cyc[1], TMO + 1);
        else check("t4_req_count", req_cyc.size(), 2);
        mfail++;
        check("t4_tmo", o_timeout, 1);
        check("t4_ok", o_verify_ok, 0);
        check("t4_cnt", o_fail_cnt, mfail);
        check("t4_busy", o_busy, 0);
        tick(150);
        check("t4_late_fail", o_verify_fail, 1);
        check("t4_late_tmo", o_timeout, 1);
        check("t4_late_cnt", o_fail_cnt, mfail);
        check("t4_late_reqs", req_q.size(), 2);
        check("t4_late_busy", o_busy, 0);
        drop_at = 0;
        pulse_clear();

        // 6: clear during WAIT of round 1, then restart
        start_id(16'h00C6);
        n = 0;
        while (req_q.size() < 2 && n < 300) begin
            tick(1);
            n++;
        end
        check("t6_req2_seen", req_q.size(), 2);
        tick(5);
        check("t6_round1", o_round, 1);
        check("t6_busy", o_busy, 1);
        pulse_clear();
        check("t6_clr_busy", o_busy, 0);
        check("t6_clr_round", o_round, 0);
        tick(lat + 10);
        check("t6_ign_busy", o_busy, 0);
        check("t6_ign_verdict", o_verify_ok | o_verify_fail, 0);
        check("t6_ign_reqs", req_q.size(), 2);
        check("t6_ign_cnt", o_fail_cnt, mfail);
        run_attempt("t6r", 16'h00C6, 256'h00C8, 0);
        pulse_clear();

        // 5: three mismatches -> lock; clear and ID ignored; reset frees
        for (int i = 0; i < MAXF; i++) begin
            run_attempt("t5", 16'h5555, 256'h0, 0);
            if (i < MAXF - 1) pulse_clear();
        end
        pulse_clear();
        req_q.delete();
        card     = 16'h7777;
        card_vld = 1'b1;
        tick(1);
        card_vld = 1'b0;
        tick(5);
        check("t5_lock_hold", o_locked, 1);
        check("t5_lock_fail", o_verify_fail, 1);
        check("t5_lock_busy", o_busy, 0);
        check("t5_lock_reqs", req_q.size(), 0);
        check("t5_lock_cnt", o_fail_cnt, MAXF);
        do_reset();
        mfail = 0;
        check("t5_rst_lock", o_locked, 0);
        check("t5_rst_fail", o_verify_fail, 0);
        check("t5_rst_cnt", o_fail_cnt, 0);

        // randomized attempts against the reference model
        for (int i = 0; i < 12; i++) begin
            lat  = $urandom_range(1, 60);
            rid  = ID_W'($urandom);
            good = DIG_W'(rid) + ROUNDS;
            if ($urandom_range(0, 1) == 1) good = good + 1 + $urandom_range(0, 1000);
            run_attempt("rnd", rid, good,
                        ($urandom_range(0, 1) == 1) ? (lat + 4) * ROUNDS + $urandom_range(20, 80) : 0);
            if (mfail >= MAXF) begin
                do_reset();
                mfail = 0;
            end else begin
                pulse_clear();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
